// File: rtl/transfer_ctrl.sv
// transfer_ctrl: ping-pong drain controller for two line scanners (A and B).
// A scanner is started, waits in SCAN until its buffer is ready, then is
// drained for exactly 100 words. A "second buffer" edge from the active
// scanner pre-launches the other one so the two scanners overlap.
// Optional feature: define XFER_TIMEOUT_EN to build an 8-bit SCAN watchdog
// that raises a sticky timeout flag; without it timeout is tied low.
module transfer_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       standby_req,
    input  logic       ready_a,
    input  logic       ready_b,
    input  logic       second_a,
    input  logic       second_b,
    output logic       start_scan_a,
    output logic       start_scan_b,
    output logic       transfer_a,
    output logic       transfer_b,
    output logic       go_to_standby,
    output logic [6:0] word_count,
    output logic       xfer_done,
    output logic       timeout
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCAN_A  = 3'd1,
        DRAIN_A = 3'd2,
        SCAN_B  = 3'd3,
        DRAIN_B = 3'd4,
        STANDBY = 3'd5
    } state_t;

    localparam logic [6:0] LAST_WORD = 7'd99;

    state_t     state_q, state_d;
    logic       start_a_q, start_a_d;
    logic       start_b_q, start_b_d;
    logic       xfer_a_q, xfer_a_d;
    logic       xfer_b_q, xfer_b_d;
    logic       stby_q, stby_d;
    logic [6:0] wc_q, wc_d;
    logic       done_q, done_d;
    logic       launched_a_q, launched_a_d;
    logic       launched_b_q, launched_b_d;
    logic       sec_a_prev_q;
    logic       sec_b_prev_q;

    logic       scanning_s;
    logic       sec_a_edge_s;
    logic       sec_b_edge_s;

`ifdef XFER_TIMEOUT_EN
    // Watchdog trips on the 255th consecutive SCAN cycle without ready.
    localparam logic [7:0] WDOG_LIMIT = 8'd254;
    logic [7:0] wdog_q, wdog_d;
    logic       timeout_q, timeout_d;
`endif

    // Second-buffer edges only matter while a scan/drain cycle is running.
    assign scanning_s   = (state_q != IDLE) && (state_q != STANDBY);
    assign sec_a_edge_s = second_a & ~sec_a_prev_q;
    assign sec_b_edge_s = second_b & ~sec_b_prev_q;

    // Next-state and next-output logic for the scan/drain sequencer.
    always_comb begin
        state_d      = state_q;
        start_a_d    = 1'b0;
        start_b_d    = 1'b0;
        xfer_a_d     = 1'b0;
        xfer_b_d     = 1'b0;
        stby_d       = 1'b0;
        wc_d         = wc_q;
        done_d       = 1'b0;
        launched_a_d = launched_a_q;
        launched_b_d = launched_b_q;
`ifdef XFER_TIMEOUT_EN
        wdog_d       = 8'd0;
        timeout_d    = timeout_q;
`endif

        // Early launch of the other scanner; a second launch is suppressed.
        if (scanning_s && sec_a_edge_s && !launched_b_q) begin
            start_b_d    = 1'b1;
            launched_b_d = 1'b1;
        end else begin
            start_b_d    = 1'b0;
        end
        if (scanning_s && sec_b_edge_s && !launched_a_q) begin
            start_a_d    = 1'b1;
            launched_a_d = 1'b1;
        end else begin
            start_a_d    = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d      = SCAN_A;
                    start_a_d    = 1'b1;
                    launched_a_d = 1'b1;
                end else if (standby_req) begin
                    state_d = STANDBY;
                    stby_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            STANDBY: begin
                if (!standby_req || enable) begin
                    state_d = IDLE;
                    stby_d  = 1'b0;
                end else begin
                    state_d = STANDBY;
                    stby_d  = 1'b1;
                end
            end

            SCAN_A: begin
                if (!enable) begin
                    state_d      = IDLE;
                    start_a_d    = 1'b0;
                    start_b_d    = 1'b0;
                    launched_a_d = 1'b0;
                    launched_b_d = 1'b0;
                end else if (ready_a) begin
                    state_d  = DRAIN_A;
                    wc_d     = 7'd0;
                    xfer_a_d = 1'b1;
                end else begin
`ifdef XFER_TIMEOUT_EN
                    if (wdog_q == WDOG_LIMIT) begin
                        timeout_d    = 1'b1;
                        state_d      = IDLE;
                        start_a_d    = 1'b0;
                        start_b_d    = 1'b0;
                        launched_a_d = 1'b0;
                        launched_b_d = 1'b0;
                    end else begin
                        wdog_d = wdog_q + 8'd1;
                    end
`else
                    state_d = SCAN_A;
`endif
                end
            end

            SCAN_B: begin
                if (!enable) begin
                    state_d      = IDLE;
                    start_a_d    = 1'b0;
                    start_b_d    = 1'b0;
                    launched_a_d = 1'b0;
                    launched_b_d = 1'b0;
                end else if (ready_b) begin
                    state_d  = DRAIN_B;
                    wc_d     = 7'd0;
                    xfer_b_d = 1'b1;
                end else begin
`ifdef XFER_TIMEOUT_EN
                    if (wdog_q == WDOG_LIMIT) begin
                        timeout_d    = 1'b1;
                        state_d      = IDLE;
                        start_a_d    = 1'b0;
                        start_b_d    = 1'b0;
                        launched_a_d = 1'b0;
                        launched_b_d = 1'b0;
                    end else begin
                        wdog_d = wdog_q + 8'd1;
                    end
`else
                    state_d = SCAN_B;
`endif
                end
            end

            DRAIN_A: begin
                if (wc_q == LAST_WORD) begin
                    done_d       = 1'b1;
                    wc_d         = 7'd0;
                    launched_a_d = 1'b0;
                    if (enable) begin
                        state_d = SCAN_B;
                        // launched_b_d already reflects any launch this cycle
                        if (!launched_b_d) begin
                            start_b_d    = 1'b1;
                            launched_b_d = 1'b1;
                        end else begin
                            launched_b_d = 1'b1;
                        end
                    end else begin
                        state_d      = IDLE;
                        start_a_d    = 1'b0;
                        start_b_d    = 1'b0;
                        launched_b_d = 1'b0;
                    end
                end else begin
                    xfer_a_d = 1'b1;
                    wc_d     = wc_q + 7'd1;
                end
            end

            DRAIN_B: begin
                if (wc_q == LAST_WORD) begin
                    done_d       = 1'b1;
                    wc_d         = 7'd0;
                    launched_b_d = 1'b0;
                    if (enable) begin
                        state_d = SCAN_A;
                        if (!launched_a_d) begin
                            start_a_d    = 1'b1;
                            launched_a_d = 1'b1;
                        end else begin
                            launched_a_d = 1'b1;
                        end
                    end else begin
                        state_d      = IDLE;
                        start_a_d    = 1'b0;
                        start_b_d    = 1'b0;
                        launched_a_d = 1'b0;
                    end
                end else begin
                    xfer_b_d = 1'b1;
                    wc_d     = wc_q + 7'd1;
                end
            end

            default: begin
                state_d      = IDLE;
                start_a_d    = 1'b0;
                start_b_d    = 1'b0;
                launched_a_d = 1'b0;
                launched_b_d = 1'b0;
                wc_d         = 7'd0;
            end
        endcase
    end

    // State register, registered outputs, launch flags and edge history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            start_a_q    <= 1'b0;
            start_b_q    <= 1'b0;
            xfer_a_q     <= 1'b0;
            xfer_b_q     <= 1'b0;
            stby_q       <= 1'b0;
            wc_q         <= 7'd0;
            done_q       <= 1'b0;
            launched_a_q <= 1'b0;
            launched_b_q <= 1'b0;
            sec_a_prev_q <= 1'b0;
            sec_b_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_a_q    <= start_a_d;
            start_b_q    <= start_b_d;
            xfer_a_q     <= xfer_a_d;
            xfer_b_q     <= xfer_b_d;
            stby_q       <= stby_d;
            wc_q         <= wc_d;
            done_q       <= done_d;
            launched_a_q <= launched_a_d;
            launched_b_q <= launched_b_d;
            sec_a_prev_q <= second_a;
            sec_b_prev_q <= second_b;
        end
    end

`ifdef XFER_TIMEOUT_EN
    // SCAN watchdog counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign start_scan_a  = start_a_q;
    assign start_scan_b  = start_b_q;
    assign transfer_a    = xfer_a_q;
    assign transfer_b    = xfer_b_q;
    assign go_to_standby = stby_q;
    assign word_count    = wc_q;
    assign xfer_done     = done_q;

endmodule

// File: tb/tb_transfer_ctrl.sv
// Self-checking bench for transfer_ctrl: a vector table for the short
// single-cycle behaviours, hand sequences for the multi-cycle drains, and a
// drain scoreboard (expected scanner pushed at stimulus, popped at xfer_done).
module tb_transfer_ctrl;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       standby_req;
    logic       ready_a;
    logic       ready_b;
    logic       second_a;
    logic       second_b;
    logic       start_scan_a;
    logic       start_scan_b;
    logic       transfer_a;
    logic       transfer_b;
    logic       go_to_standby;
    logic [6:0] word_count;
    logic       xfer_done;
    logic       timeout;

    transfer_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .standby_req  (standby_req),
        .ready_a      (ready_a),
        .ready_b      (ready_b),
        .second_a     (second_a),
        .second_b     (second_b),
        .start_scan_a (start_scan_a),
        .start_scan_b (start_scan_b),
        .transfer_a   (transfer_a),
        .transfer_b   (transfer_b),
        .go_to_standby(go_to_standby),
        .word_count   (word_count),
        .xfer_done    (xfer_done),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       sb;
        logic       ra;
        logic       rb;
        logic       sa;
        logic       sbr;
        int         push;
        logic       e_sa;
        logic       e_sb;
        logic       e_ta;
        logic       e_tb;
        logic       e_gs;
        logic       e_xd;
        logic [6:0] e_wc;
    } vec_t;

    vec_t vecs [16];

    int n_checks = 0;
    int n_err    = 0;
    int exp_q [$];
    int run_a = 0;
    int run_b = 0;
    int wc_bad = 0;
    int overlap_cnt = 0;
    int n_start_a = 0;
    int n_start_b = 0;
    int n_done = 0;
    int s0;
    int d0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: sample #1 after the edge and update the drain scoreboard.
    task automatic tick();
        int id;
        int len;
        @(posedge clk);
        #1;
        if (transfer_a && transfer_b) overlap_cnt++;
        if (transfer_a) begin
            if (int'(word_count) != run_a) wc_bad++;
            run_a++;
        end
        if (transfer_b) begin
            if (int'(word_count) != run_b) wc_bad++;
            run_b++;
        end
        if (start_scan_a) n_start_a++;
        if (start_scan_b) n_start_b++;
        if (xfer_done) begin
            n_done++;
            id  = (run_a > 0) ? 1 : 2;
            len = (run_a > 0) ? run_a : run_b;
            check("sb_pending", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                check("sb_drain_id", id, exp_q.pop_front());
                check("sb_drain_len", len, 32'd100);
                check("sb_word_seq", wc_bad, 32'd0);
            end
            run_a  = 0;
            run_b  = 0;
            wc_bad = 0;
        end
    endtask

    task automatic wait_done(input int bound);
        int   n   = 0;
        logic got = 1'b0;
        while (!got && n < bound) begin
            tick();
            n++;
            got = xfer_done;
        end
        check("done_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_wc(input int target, input int bound);
        int n = 0;
        while (!((transfer_a || transfer_b) && int'(word_count) == target) && n < bound) begin
            tick();
            n++;
        end
        check($sformatf("reach_wc%0d", target), {25'd0, word_count}, target);
    endtask

    initial begin
        #1000000;
        $display("FAIL sim_time_limit: got no finish, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        //          en    sb    ra    rb    sa    sbr  push  e_sa  e_sb  e_ta  e_tb  e_gs  e_xd  e_wc
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd2};

        rst = 1'b0;
        enable = 1'b0; standby_req = 1'b0;
        ready_a = 1'b0; ready_b = 1'b0; second_a = 1'b0; second_b = 1'b0;
        #23;
        check("rst_start_a", {31'd0, start_scan_a}, 32'd0);
        check("rst_start_b", {31'd0, start_scan_b}, 32'd0);
        check("rst_transfer_a", {31'd0, transfer_a}, 32'd0);
        check("rst_transfer_b", {31'd0, transfer_b}, 32'd0);
        check("rst_standby", {31'd0, go_to_standby}, 32'd0);
        check("rst_word_count", {25'd0, word_count}, 32'd0);
        check("rst_xfer_done", {31'd0, xfer_done}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        #4 rst = 1'b1;

        // Standby entry/exit, launch handling, SCAN exit and drain start.
        for (int i = 0; i < 16; i++) begin
            enable = vecs[i].en; standby_req = vecs[i].sb;
            ready_a = vecs[i].ra; ready_b = vecs[i].rb;
            second_a = vecs[i].sa; second_b = vecs[i].sbr;
            if (vecs[i].push != 0) exp_q.push_back(vecs[i].push);
            tick();
            check($sformatf("vec%0d", i),
                  {19'd0, start_scan_a, start_scan_b, transfer_a, transfer_b, go_to_standby, xfer_done, word_count},
                  {19'd0, vecs[i].e_sa, vecs[i].e_sb, vecs[i].e_ta, vecs[i].e_tb, vecs[i].e_gs, vecs[i].e_xd, vecs[i].e_wc});
        end

        // Enable dropped early in the drain: full drain, then IDLE.
        s0 = n_start_b;
        wait_done(150);
        check("drain_a_no_start_b", n_start_b - s0, 32'd0);
        enable = 1'b1;
        tick();
        check("idle_after_drain", {31'd0, start_scan_a}, 32'd1);

        // Enable dropped at word 50: drain still completes, then IDLE.
        ready_a = 1'b1; exp_q.push_back(1);
        tick();
        ready_a = 1'b0;
        check("drain50_transfer_a", {31'd0, transfer_a}, 32'd1);
        wait_wc(50, 120);
        enable = 1'b0;
        d0 = n_done;
        wait_done(120);
        check("drain50_one_done", n_done - d0, 32'd1);
        enable = 1'b1;
        tick();
        check("drain50_idle", {31'd0, start_scan_a}, 32'd1);

        // Second-buffer pre-launch of B, ready_b held off during DRAIN_A.
        ready_a = 1'b1; exp_q.push_back(1);
        tick();
        ready_a = 1'b0;
        wait_wc(30, 100);
        second_a = 1'b1; ready_b = 1'b1; exp_q.push_back(2);
        s0 = n_start_b;
        tick();
        second_a = 1'b0;
        check("prelaunch_start_b", {31'd0, start_scan_b}, 32'd1);
        check("ready_b_held_off", {31'd0, transfer_b}, 32'd0);
        wait_done(100);
        check("single_start_b", n_start_b - s0, 32'd1);
        tick();
        check("drain_b_started", {31'd0, transfer_b}, 32'd1);
        ready_b = 1'b0;
        wait_done(120);
        check("reentry_start_a", {31'd0, start_scan_a}, 32'd1);
        check("still_single_start_b", n_start_b - s0, 32'd1);

        // Asynchronous reset at word 40 aborts the drain with no done pulse.
        ready_a = 1'b1; exp_q.push_back(1);
        tick();
        ready_a = 1'b0;
        wait_wc(40, 100);
        d0 = n_done;
        #1 rst = 1'b0;
        #1;
        check("abort_transfer_a", {31'd0, transfer_a}, 32'd0);
        check("abort_word_count", {25'd0, word_count}, 32'd0);
        check("abort_xfer_done", {31'd0, xfer_done}, 32'd0);
        exp_q.delete();
        run_a = 0; run_b = 0; wc_bad = 0;
        enable = 1'b0;
        #1 rst = 1'b1;
        repeat (3) tick();
        check("abort_no_done", n_done - d0, 32'd0);
        check("abort_stays_off", {31'd0, transfer_a}, 32'd0);
        enable = 1'b1;
        tick();
        check("abort_idle", {31'd0, start_scan_a}, 32'd1);

`ifdef XFER_TIMEOUT_EN
        // Watchdog: 255 SCAN cycles without ready sets sticky timeout.
        repeat (254) tick();
        check("no_early_timeout", {31'd0, timeout}, 32'd0);
        tick();
        check("timeout_set", {31'd0, timeout}, 32'd1);
        tick();
        check("timeout_to_idle", {31'd0, start_scan_a}, 32'd1);
        enable = 1'b0;
        repeat (3) tick();
        check("timeout_sticky", {31'd0, timeout}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("timeout_reset", {31'd0, timeout}, 32'd0);
        #1 rst = 1'b1;
`else
        // No watchdog: SCAN waits indefinitely, timeout stays low.
        repeat (300) tick();
        check("timeout_tied_low", {31'd0, timeout}, 32'd0);
        ready_a = 1'b1; exp_q.push_back(1);
        tick();
        ready_a = 1'b0;
        check("scan_waits_forever", {31'd0, transfer_a}, 32'd1);
        enable = 1'b0;
        wait_done(120);
`endif

        check("sb_queue_empty", exp_q.size(), 32'd0);
        check("no_overlap", overlap_cnt, 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
